// File: rtl/argmax_seg7_classifier.sv
// Output stage of the digit classifier. It takes one frame of signed class
// scores over a valid/ready stream and finds the argmax. It latches the
// winning index and score, and shows the index on a 7-segment display.
module argmax_seg7_classifier #(
  parameter int N_CLASSES      = 10,
  parameter int SCORE_W        = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [SCORE_W-1:0] s_score,
  input  logic                      s_last,
  output logic                      cls_valid,
  output logic [3:0]                cls_idx,
  output logic signed [SCORE_W-1:0] cls_score,
  output logic                      cls_err,
  output logic [7:0]                n_results,
  output logic                      busy,
  output logic [6:0]                segments
);

  localparam int              IDX_W     = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);
  localparam logic [6:0]      SEG_DASH  = 7'h40;
  localparam logic [6:0]      SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Active-high segment pattern {g,f,e,d,c,b,a} for a hex digit.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'h0:    pattern = 7'h3F;
      4'h1:    pattern = 7'h06;
      4'h2:    pattern = 7'h5B;
      4'h3:    pattern = 7'h4F;
      4'h4:    pattern = 7'h66;
      4'h5:    pattern = 7'h6D;
      4'h6:    pattern = 7'h7D;
      4'h7:    pattern = 7'h07;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h6F;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h7C;
      4'hC:    pattern = 7'h39;
      4'hD:    pattern = 7'h5E;
      4'hE:    pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    return pattern;
  endfunction

  // A common-anode display needs every segment inverted.
  function automatic logic [6:0] seg_polarity(input logic [6:0] raw);
    return SEG_ACTIVE_LOW ? ~raw : raw;
  endfunction

  state_t                    state_q, state_d;
  logic signed [SCORE_W-1:0] best_q;
  logic [IDX_W-1:0]          best_idx_q;
  logic [IDX_W-1:0]          cnt_q;

  logic                      accept;
  logic                      take_beat;
  logic                      frame_end;
  logic                      frame_err;
  logic [IDX_W-1:0]          beat_idx;
  logic [IDX_W-1:0]          cand_idx;
  logic signed [SCORE_W-1:0] cand_score;

  assign s_ready   = (state_q != RESULT);
  assign busy      = (state_q == ACCUM);
  assign cls_valid = (state_q == RESULT);

  assign accept   = s_valid && s_ready;
  assign beat_idx = (state_q == IDLE) ? '0 : cnt_q;

  // The first beat of a frame always wins. Later beats win only on a strict
  // signed greater-than, so ties keep the lower index.
  assign take_beat  = (state_q == IDLE) || (s_score > best_q);
  assign cand_score = take_beat ? s_score  : best_q;
  assign cand_idx   = take_beat ? beat_idx : best_idx_q;

  // A frame ends on the first of s_last or the last class slot. It is clean
  // only when both happen on the same beat.
  assign frame_end = accept && (s_last || (beat_idx == LAST_IDX));
  assign frame_err = !(s_last && (beat_idx == LAST_IDX));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, whatever order the blocks are evaluated in.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. RESULT lasts exactly one cycle.
  always_comb begin
    // NOTE: the default comes first, so every path assigns state_d and no latch
    // is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = frame_end ? RESULT : ACCUM;
      end
      ACCUM: begin
        if (frame_end) state_d = RESULT;
      end
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Running maximum and beat counter. They hold while s_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q     <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
    end else if (accept) begin
      best_q     <= cand_score;
      best_idx_q <= cand_idx;
      cnt_q      <= beat_idx + 1'b1;
    end
  end

  // Result registers. They load on the edge that enters RESULT and then hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cls_idx   <= '0;
      cls_score <= '0;
      cls_err   <= 1'b0;
      n_results <= '0;
      segments  <= SEG_BLANK;
    end else if (frame_end) begin
      cls_idx   <= cand_idx;
      cls_score <= cand_score;
      cls_err   <= frame_err;
      n_results <= n_results + 8'd1;
      segments  <= seg_polarity(frame_err ? SEG_DASH : seg_encode(cand_idx));
    end
  end

endmodule

// File: tb/tb_argmax_seg7_classifier.sv
// Directed bench for argmax_seg7_classifier. It runs the default 10-class
// instance and a 16-class active-low instance on shared input signals.
module tb_argmax_seg7_classifier;

  typedef logic signed [15:0] frame_t [16];

  logic clk = 1'b0;
  logic rst;
  logic s_valid;
  logic signed [15:0] s_score;
  logic s_last;

  logic        s_ready, cls_valid, cls_err, busy;
  logic [3:0]  cls_idx;
  logic signed [15:0] cls_score;
  logic [7:0]  n_results;
  logic [6:0]  segments;

  logic        d2_s_ready, d2_cls_valid, d2_cls_err, d2_busy;
  logic [3:0]  d2_cls_idx;
  logic signed [15:0] d2_cls_score;
  logic [7:0]  d2_n_results;
  logic [6:0]  d2_segments;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stalls = 0;
  int vcyc[$];
  int vidx[$];

  always #5 clk = ~clk;

  argmax_seg7_classifier #(.N_CLASSES(10), .SCORE_W(16), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_score(s_score),
    .s_last(s_last), .cls_valid(cls_valid), .cls_idx(cls_idx), .cls_score(cls_score),
    .cls_err(cls_err), .n_results(n_results), .busy(busy), .segments(segments)
  );

  argmax_seg7_classifier #(.N_CLASSES(16), .SCORE_W(16), .SEG_ACTIVE_LOW(1'b1)) dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(d2_s_ready), .s_score(s_score),
    .s_last(s_last), .cls_valid(d2_cls_valid), .cls_idx(d2_cls_idx), .cls_score(d2_cls_score),
    .cls_err(d2_cls_err), .n_results(d2_n_results), .busy(d2_busy), .segments(d2_segments)
  );

  // Cycle count, plus a log of every result pulse of the 10-class instance.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cls_valid) begin
      vcyc.push_back(cyc);
      vidx.push_back(int'(cls_idx));
    end
  end

  // Offer one beat after an optional gap. Hold it until ready, then return
  // just after the accepting edge.
  task automatic put_beat(input logic signed [15:0] sc, input logic last,
                          input bit use2, input int gap);
    int guard;
    @(negedge clk);
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    s_valid = 1'b1;
    s_score = sc;
    s_last  = last;
    guard   = 0;
    while ((use2 ? d2_s_ready : s_ready) !== 1'b1 && guard < 50) begin
      stalls++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: s_ready low for %0d cycles, required 1", guard);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input frame_t sc, input int n, input int last_at,
                            input bit use2, input int maxgap);
    for (int i = 0; i < n; i++)
      put_beat(sc[i], (i == last_at), use2, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_score = '0;
    repeat (2) @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", s_ready); end
    checks++; if (cls_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", cls_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (segments !== 7'h00) begin errors++; $display("FAIL reset_seg got %h exp 00", segments); end
    checks++; if (n_results !== 8'd0) begin errors++; $display("FAIL reset_nres got %0d exp 0", n_results); end
    checks++; if (cls_idx !== 4'd0 || cls_err !== 1'b0) begin errors++; $display("FAIL reset_idx_err got %0d/%b exp 0/0", cls_idx, cls_err); end
    checks++; if (d2_segments !== 7'h7F) begin errors++; $display("FAIL reset_seg_al got %h exp 7f", d2_segments); end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    frame_t f = '{5, -3, 12, 7, 12, 0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0};
    send_frame(f, 10, 9, 1'b0, 0);
    @(negedge clk);
    checks++; if (cls_valid !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL basic_pulse got valid %b ready %b exp 1 0", cls_valid, s_ready); end
    checks++; if (cls_idx !== 4'd2) begin errors++; $display("FAIL basic_idx got %0d exp 2", cls_idx); end
    checks++; if (cls_score !== 16'sd12) begin errors++; $display("FAIL basic_score got %0d exp 12", cls_score); end
    checks++; if (cls_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", cls_err); end
    checks++; if (segments !== 7'h5B) begin errors++; $display("FAIL basic_seg got %h exp 5b", segments); end
    checks++; if (n_results !== 8'd1) begin errors++; $display("FAIL basic_nres got %0d exp 1", n_results); end
    @(negedge clk);
    checks++; if (cls_valid !== 1'b0 || s_ready !== 1'b1 || segments !== 7'h5B) begin errors++; $display("FAIL basic_after got valid %b ready %b seg %h exp 0 1 5b", cls_valid, s_ready, segments); end
  endtask

  task automatic test_back_to_back();
    frame_t f0 = '{1, 2, 3, 50, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0};
    frame_t f1 = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 40, 0, 0, 0, 0, 0, 0};
    frame_t f2 = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10, 0, 0, 0, 0, 0, 0};
    int tcyc[3];
    int eidx[3] = '{3, 9, 0};
    vcyc.delete();
    vidx.delete();
    stalls = 0;
    send_frame(f0, 10, 9, 1'b0, 0); tcyc[0] = cyc;
    send_frame(f1, 10, 9, 1'b0, 0); tcyc[1] = cyc;
    send_frame(f2, 10, 9, 1'b0, 0); tcyc[2] = cyc;
    repeat (2) @(negedge clk);
    checks++; if (stalls !== 2) begin errors++; $display("FAIL b2b_stalls got %0d exp 2", stalls); end
    checks++; if (vcyc.size() !== 3) begin errors++; $display("FAIL b2b_pulses got %0d exp 3", vcyc.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < vcyc.size()) begin
        checks++; if (vcyc[k] !== tcyc[k]) begin errors++; $display("FAIL b2b_latency%0d got cycle %0d exp %0d", k, vcyc[k], tcyc[k]); end
        checks++; if (vidx[k] !== eidx[k]) begin errors++; $display("FAIL b2b_idx%0d got %0d exp %0d", k, vidx[k], eidx[k]); end
      end
    end
    checks++; if (n_results !== 8'd4) begin errors++; $display("FAIL b2b_nres got %0d exp 4", n_results); end
  endtask

  task automatic test_early_last();
    frame_t f  = '{3, 1, 4, 1, 5, 9, 2, 20, 0, 0, 0, 0, 0, 0, 0, 0};
    frame_t g  = '{8, 1, 2, 3, 4, 5, 6, 7, 8, 1, 0, 0, 0, 0, 0, 0};
    send_frame(f, 6, 5, 1'b0, 0);
    @(negedge clk);
    checks++; if (cls_valid !== 1'b1) begin errors++; $display("FAIL early_pulse got %b exp 1", cls_valid); end
    checks++; if (cls_idx !== 4'd5 || cls_score !== 16'sd9) begin errors++; $display("FAIL early_result got %0d/%0d exp 5/9", cls_idx, cls_score); end
    checks++; if (cls_err !== 1'b1 || segments !== 7'h40) begin errors++; $display("FAIL early_err got %b seg %h exp 1 40", cls_err, segments); end
    send_frame(g, 10, 9, 1'b0, 0);
    @(negedge clk);
    checks++; if (cls_idx !== 4'd0 || cls_score !== 16'sd8) begin errors++; $display("FAIL early_next got %0d/%0d exp 0/8", cls_idx, cls_score); end
    checks++; if (cls_err !== 1'b0 || segments !== 7'h3F || n_results !== 8'd6) begin errors++; $display("FAIL early_next_disp got err %b seg %h n %0d exp 0 3f 6", cls_err, segments, n_results); end
  endtask

  task automatic test_missing_last();
    frame_t f;
    for (int i = 0; i < 16; i++) f[i] = 16'sh8000;
    send_frame(f, 9, -1, 1'b0, 0);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || cls_valid !== 1'b0) begin errors++; $display("FAIL nolast_mid got busy %b valid %b exp 1 0", busy, cls_valid); end
    put_beat(16'sh8000, 1'b0, 1'b0, 0);
    @(negedge clk);
    checks++; if (cls_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL nolast_end got valid %b busy %b exp 1 0", cls_valid, busy); end
    checks++; if (cls_idx !== 4'd0 || cls_score !== 16'sh8000) begin errors++; $display("FAIL nolast_result got %0d/%h exp 0/8000", cls_idx, cls_score); end
    checks++; if (cls_err !== 1'b1 || segments !== 7'h40) begin errors++; $display("FAIL nolast_err got %b seg %h exp 1 40", cls_err, segments); end
  endtask

  task automatic test_reset_mid_frame();
    frame_t f = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -1, 0, 0, 0, 0, 0, 0};
    send_frame(f, 5, -1, 1'b0, 0);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got %b exp 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state got busy %b ready %b exp 0 1", busy, s_ready); end
    checks++; if (segments !== 7'h00 || n_results !== 8'd0) begin errors++; $display("FAIL rstmid_disp got seg %h n %0d exp 00 0", segments, n_results); end
    rst = 1'b0;
    send_frame(f, 10, 9, 1'b0, 0);
    @(negedge clk);
    checks++; if (cls_idx !== 4'd8 || cls_score !== 16'sd9 || cls_err !== 1'b0) begin errors++; $display("FAIL rstmid_frame got %0d/%0d/%b exp 8/9/0", cls_idx, cls_score, cls_err); end
    checks++; if (segments !== 7'h7F || n_results !== 8'd1) begin errors++; $display("FAIL rstmid_frame_disp got seg %h n %0d exp 7f 1", segments, n_results); end
  endtask

  task automatic test_active_low_16();
    frame_t f;
    logic signed [15:0] best;
    int bi;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) f[i] = 16'(i * 3 - 20);
    f[14] = 16'sd100;
    send_frame(f, 16, 15, 1'b1, 3);
    @(negedge clk);
    checks++; if (d2_cls_valid !== 1'b1) begin errors++; $display("FAIL al_pulse got %b exp 1", d2_cls_valid); end
    checks++; if (d2_cls_idx !== 4'd14 || d2_cls_score !== 16'sd100) begin errors++; $display("FAIL al_result got %0d/%0d exp 14/100", d2_cls_idx, d2_cls_score); end
    checks++; if (d2_segments !== 7'h06 || d2_cls_err !== 1'b0) begin errors++; $display("FAIL al_seg got %h err %b exp 06 0", d2_segments, d2_cls_err); end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) f[i] = 16'($urandom_range(0, 255)) - 16'sd128;
      f[r + 5] = f[r + 2];
      best = f[0];
      bi   = 0;
      for (int i = 1; i < 16; i++) if (f[i] > best) begin best = f[i]; bi = i; end
      send_frame(f, 16, 15, 1'b1, 3);
      @(negedge clk);
      checks++; if (d2_cls_idx !== 4'(bi) || d2_cls_score !== best) begin errors++; $display("FAIL al_rand%0d got %0d/%0d exp %0d/%0d", r, d2_cls_idx, d2_cls_score, bi, best); end
      checks++; if (d2_n_results !== 8'(r + 2)) begin errors++; $display("FAIL al_nres%0d got %0d exp %0d", r, d2_n_results, r + 2); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_early_last();
    test_missing_last();
    test_reset_mid_frame();
    test_active_low_16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
